// File: rtl/fir_decimator_pkg.sv
// Shared types and constants for the post-FIR decimation stage.
// Holds the mode encoding, the latched frame configuration and the ratio clamp.
package fir_decimator_pkg;

    localparam int DECIM_DATA_WIDTH = 12;
    localparam int DECIM_MAX_LOG2   = 7;
    localparam int DECIM_MODE_W     = 2;
    localparam int DECIM_K_W        = 3;

    typedef enum logic [DECIM_MODE_W-1:0] {
        MODE_SAMPLE  = 2'd0,
        MODE_AVERAGE = 2'd1,
        MODE_PEAK    = 2'd2,
        MODE_RSVD    = 2'd3
    } decim_mode_e;

    typedef struct packed {
        decim_mode_e          mode;
        logic [DECIM_K_W-1:0] k;
    } decim_cfg_t;

    function automatic logic [DECIM_K_W-1:0] clamp_k(input logic [DECIM_K_W-1:0] k,
                                                     input int max_log2);
        logic [DECIM_K_W-1:0] k_max;
        k_max = DECIM_K_W'(max_log2);
        return (k > k_max) ? k_max : k;
    endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// Sample stream into the decimator and decimated result stream out of it.
// The upstream/consumer side uses master; the decimator uses slave.
interface fir_decimator_if
    import fir_decimator_pkg::*;
#(
    parameter int DATA_WIDTH = DECIM_DATA_WIDTH
);

    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic signed [DATA_WIDTH-1:0] data_min;
    logic signed [DATA_WIDTH-1:0] data_max;

    modport master (
        output in_valid,
        output data_in,
        input  out_valid,
        input  data_out,
        input  data_min,
        input  data_max
    );

    modport slave (
        input  in_valid,
        input  data_in,
        output out_valid,
        output data_out,
        output data_min,
        output data_max
    );

endinterface

// File: rtl/fir_decimator_frame_ctr.sv
// Frame position counter: tracks the sample index inside a 2^k frame, latches the
// configuration at frame start and flags the first and last sample of each frame.
module fir_decimator_frame_ctr
    import fir_decimator_pkg::*;
#(
    parameter int MAX_LOG2 = DECIM_MAX_LOG2
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    restart,
    input  logic                    in_valid,
    input  logic [DECIM_MODE_W-1:0] mode,
    input  logic [DECIM_K_W-1:0]    log2_ratio,
    output decim_cfg_t              cfg,
    output logic                    first,
    output logic                    last
);

    localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_eff;
    logic [CNT_W-1:0] last_idx;
    logic [CNT_W:0]   frame_len;
    decim_cfg_t       cfg_q;
    decim_cfg_t       cfg_port;

    // restart realigns in the same cycle, so a coincident sample is index 0
    always_comb begin
        cfg_port.mode = decim_mode_e'(mode);
        cfg_port.k    = clamp_k(log2_ratio, MAX_LOG2);
        cnt_eff       = restart ? '0 : cnt_q;
        first         = in_valid && (cnt_eff == '0);
        cfg           = first ? cfg_port : cfg_q;
        frame_len     = (CNT_W+1)'(1) << cfg.k;
        last_idx      = CNT_W'(frame_len - (CNT_W+1)'(1));
        last          = in_valid && (cnt_eff == last_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            cfg_q.mode <= MODE_SAMPLE;
            cfg_q.k    <= '0;
        end else if (in_valid) begin
            cnt_q <= last ? '0 : (cnt_eff + CNT_W'(1));
            if (first) begin
                cfg_q <= cfg_port;
            end
        end else if (restart) begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// Post-filter decimation stage: reduces the FIR sample rate by 2^k and emits one
// SAMPLE, AVERAGE or PEAK result per frame, one clock after the frame's last sample.
module fir_decimator
    import fir_decimator_pkg::*;
#(
    parameter int DATA_WIDTH = DECIM_DATA_WIDTH,
    parameter int MAX_LOG2   = DECIM_MAX_LOG2
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    restart,
    input  logic [DECIM_MODE_W-1:0] mode,
    input  logic [DECIM_K_W-1:0]    log2_ratio,
    fir_decimator_if.slave          stream
);

    localparam int ACC_W = DATA_WIDTH + MAX_LOG2;

    decim_cfg_t cfg;
    logic       first;
    logic       last;

    logic signed [DATA_WIDTH-1:0] din;
    logic signed [ACC_W-1:0]      sample_ext;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      acc_nxt;
    logic signed [DATA_WIDTH-1:0] min_q;
    logic signed [DATA_WIDTH-1:0] max_q;
    logic signed [DATA_WIDTH-1:0] first_q;
    logic signed [DATA_WIDTH-1:0] min_nxt;
    logic signed [DATA_WIDTH-1:0] max_nxt;
    logic signed [DATA_WIDTH-1:0] first_nxt;
    logic signed [DATA_WIDTH-1:0] avg;
    logic signed [DATA_WIDTH-1:0] result;

    logic                         out_valid_q;
    logic signed [DATA_WIDTH-1:0] data_out_q;
    logic signed [DATA_WIDTH-1:0] data_min_q;
    logic signed [DATA_WIDTH-1:0] data_max_q;

    fir_decimator_frame_ctr #(
        .MAX_LOG2   (MAX_LOG2)
    ) u_frame_ctr (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .in_valid   (stream.in_valid),
        .mode       (mode),
        .log2_ratio (log2_ratio),
        .cfg        (cfg),
        .first      (first),
        .last       (last)
    );

    assign din        = stream.data_in;
    assign sample_ext = {{MAX_LOG2{din[DATA_WIDTH-1]}}, din};

    // Next-state values include the current sample so the last sample of a frame
    // feeds straight into the result register without an extra cycle.
    always_comb begin
        if (first) begin
            acc_nxt   = sample_ext;
            min_nxt   = din;
            max_nxt   = din;
            first_nxt = din;
        end else begin
            acc_nxt   = acc_q + sample_ext;
            min_nxt   = (din < min_q) ? din : min_q;
            max_nxt   = (din > max_q) ? din : max_q;
            first_nxt = first_q;
        end

        avg = DATA_WIDTH'(acc_nxt >>> cfg.k);

        case (cfg.mode)
            MODE_AVERAGE: result = avg;
            MODE_PEAK:    result = max_nxt;
            default:      result = first_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            first_q     <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            data_min_q  <= '0;
            data_max_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (stream.in_valid) begin
                acc_q   <= acc_nxt;
                min_q   <= min_nxt;
                max_q   <= max_nxt;
                first_q <= first_nxt;
                if (last) begin
                    out_valid_q <= 1'b1;
                    data_out_q  <= result;
                    data_min_q  <= (cfg.mode == MODE_PEAK) ? min_nxt : result;
                    data_max_q  <= (cfg.mode == MODE_PEAK) ? max_nxt : result;
                end
            end
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.data_out  = data_out_q;
    assign stream.data_min  = data_min_q;
    assign stream.data_max  = data_max_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: hand-computed frames in every mode, ratio edges,
// restart, mid-frame config changes, input gaps and mid-frame reset.
module tb_fir_decimator;

    logic       clk;
    logic       rst;
    logic       restart;
    logic [1:0] mode;
    logic [2:0] log2_ratio;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_cyc    = 0;

    int q_out[$];
    int q_min[$];
    int q_max[$];
    int q_cyc[$];

    fir_decimator_if #(.DATA_WIDTH(12)) bus ();

    fir_decimator dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .mode       (mode),
        .log2_ratio (log2_ratio),
        .stream     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            q_out.push_back(int'($signed(bus.data_out)));
            q_min.push_back(int'($signed(bus.data_min)));
            q_max.push_back(int'($signed(bus.data_max)));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int v);
        @(negedge clk);
        restart      = 1'b0;
        bus.in_valid = 1'b1;
        bus.data_in  = v[11:0];
        last_cyc     = cyc;
    endtask

    task automatic send_restart(input int v);
        @(negedge clk);
        restart      = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in  = v[11:0];
        last_cyc     = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            restart      = 1'b0;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [2:0] k);
        mode       = m;
        log2_ratio = k;
    endtask

    task automatic clear_q();
        q_out.delete();
        q_min.delete();
        q_max.delete();
        q_cyc.delete();
    endtask

    task automatic expect_one(input string tag, input int o, input int mn, input int mx);
        check({tag, "_count"}, q_out.size(), 1);
        if (q_out.size() == 1) begin
            check({tag, "_out"}, q_out[0], o);
            check({tag, "_min"}, q_min[0], mn);
            check({tag, "_max"}, q_max[0], mx);
            check({tag, "_lat"}, q_cyc[0] - last_cyc, 1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        restart      = 1'b0;
        mode         = 2'd0;
        log2_ratio   = 3'd0;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_out",   int'($signed(bus.data_out)), 0);
        check("rst_min",   int'($signed(bus.data_min)), 0);
        check("rst_max",   int'($signed(bus.data_max)), 0);
        rst = 1'b0;
        idle(2);

        // SAMPLE k=2
        clear_q(); set_cfg(2'd0, 3'd2);
        send(-3); send(1); send(0); send(-2); idle(3);
        expect_one("sample_k2", -3, -3, -3);

        // AVERAGE k=2, floor of -4/4 and 5/4
        clear_q(); set_cfg(2'd1, 3'd2);
        send(-3); send(1); send(0); send(-2); idle(3);
        expect_one("avg_neg", -1, -1, -1);
        clear_q();
        send(4); send(-5); send(6); send(0); idle(3);
        expect_one("avg_pos", 1, 1, 1);

        // PEAK k=2
        clear_q(); set_cfg(2'd2, 3'd2);
        send(-2); send(-1); send(4); send(-5); idle(3);
        expect_one("peak_k2", 4, -5, 4);

        // AVERAGE k=7 at both full-scale extremes
        clear_q(); set_cfg(2'd1, 3'd7);
        for (int i = 0; i < 128; i++) send(2047);
        idle(3);
        expect_one("avg_k7_pos", 2047, 2047, 2047);
        clear_q();
        for (int i = 0; i < 128; i++) send(-2048);
        idle(3);
        expect_one("avg_k7_neg", -2048, -2048, -2048);

        // k=0: every sample is a frame
        clear_q(); set_cfg(2'd0, 3'd0);
        send(5); send(-7); idle(3);
        check("k0_count", q_out.size(), 2);
        if (q_out.size() == 2) begin
            check("k0_out0", q_out[0], 5);
            check("k0_out1", q_out[1], -7);
            check("k0_gap",  q_cyc[1] - q_cyc[0], 1);
            check("k0_lat",  q_cyc[1] - last_cyc, 1);
        end
        clear_q(); set_cfg(2'd2, 3'd0);
        send(3); idle(3);
        expect_one("k0_peak", 3, 3, 3);

        // restart after 2 of 4, together with a valid sample
        clear_q(); set_cfg(2'd0, 3'd2);
        send(10); send(11); send_restart(6); send(7); send(8); send(9); idle(3);
        expect_one("restart_mid", 6, 6, 6);

        // restart on the completing sample discards that frame
        clear_q();
        send(1); send(2); send(3); send_restart(4); send(5); send(6); send(7); idle(3);
        expect_one("restart_last", 4, 4, 4);

        // mode/k change mid-frame applies from the next frame
        clear_q(); set_cfg(2'd0, 3'd2);
        send(3); send(4);
        set_cfg(2'd1, 3'd1);
        send(5); send(6);
        send(8); send(11); idle(3);
        check("cfgchg_count", q_out.size(), 2);
        if (q_out.size() == 2) begin
            check("cfgchg_old", q_out[0], 3);
            check("cfgchg_new", q_out[1], 9);
            check("cfgchg_min", q_min[1], 9);
        end

        // gaps of 3 idle cycles between samples
        clear_q(); set_cfg(2'd1, 3'd2);
        send(4); idle(3); send(-5); idle(3); send(6); idle(3); send(0); idle(3);
        expect_one("gaps", 1, 1, 1);

        // back-to-back frames without a dead cycle
        clear_q(); set_cfg(2'd1, 3'd1);
        send(2); send(4); send(6); send(8); idle(3);
        check("b2b_count", q_out.size(), 2);
        if (q_out.size() == 2) begin
            check("b2b_out0", q_out[0], 3);
            check("b2b_out1", q_out[1], 7);
            check("b2b_gap",  q_cyc[1] - q_cyc[0], 2);
        end

        // reserved mode behaves as SAMPLE
        clear_q(); set_cfg(2'd3, 3'd1);
        send(9); send(-1); idle(3);
        expect_one("rsvd", 9, 9, 9);

        // reset mid-frame
        clear_q(); set_cfg(2'd0, 3'd2);
        send(1); send(2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        check("midrst_valid", int'(bus.out_valid), 0);
        check("midrst_out",   int'($signed(bus.data_out)), 0);
        check("midrst_min",   int'($signed(bus.data_min)), 0);
        check("midrst_max",   int'($signed(bus.data_max)), 0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_none", q_out.size(), 0);
        send(7); send(8); send(9); send(10); idle(3);
        expect_one("after_rst", 7, 7, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
